// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch sequencer: owns the fetch PC, prefetches ROM words into a small queue, handles redirects and address faults.
// First word is valid two edges after reset release and one edge after a redirect; fetch stalls while the queue is full and decode holds off.
module imem_fetch_ctrl #(
  parameter int                    DATA_WIDTH   = 32,
  parameter int                    MEMORY_DEPTH = 256,
  parameter logic [DATA_WIDTH-1:0] BASE_ADDR    = 32'h0040_0000,
  parameter int                    QUEUE_DEPTH  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic [DATA_WIDTH-1:0] mem_address_o,
  input  logic [DATA_WIDTH-1:0] mem_instruction_i,
  input  logic                  redirect_i,
  input  logic [DATA_WIDTH-1:0] redirect_pc_i,
  input  logic                  ir_ready_i,
  output logic                  ir_valid_o,
  output logic [DATA_WIDTH-1:0] instruction_o,
  output logic [DATA_WIDTH-1:0] pc_o,
  output logic [DATA_WIDTH-1:0] pc_plus4_o,
  output logic                  fault_o,
  output logic [DATA_WIDTH-1:0] fault_pc_o,
  output logic [31:0]           retired_count_o
);

  localparam int PW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int CW = PW + 1;
  // One bit wider so the end-of-ROM bound cannot overflow.
  localparam logic [DATA_WIDTH:0] LIMIT = {1'b0, BASE_ADDR} + (DATA_WIDTH+1)'(4 * MEMORY_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FAULT} state_t;

  state_t                state_q, state_nxt;
  logic [DATA_WIDTH-1:0] fetch_pc;
  logic [DATA_WIDTH-1:0] q_pc  [QUEUE_DEPTH];
  logic [DATA_WIDTH-1:0] q_ins [QUEUE_DEPTH];
  logic [PW-1:0]         head, tail;
  logic [CW-1:0]         count;

  logic pop, push, flush, load_pc, raise_fault, clear_fault, illegal;

  assign illegal = (fetch_pc[1:0] != 2'b00) || (fetch_pc < BASE_ADDR) ||
                   ({1'b0, fetch_pc} >= LIMIT);
  assign pop     = ir_valid_o && ir_ready_i && !redirect_i;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_nxt;
  end

  always_comb begin
    state_nxt   = state_q;
    push        = 1'b0;
    flush       = 1'b0;
    load_pc     = 1'b0;
    raise_fault = 1'b0;
    clear_fault = 1'b0;
    case (state_q)
      S_IDLE: state_nxt = S_RUN;
      S_RUN: begin
        if (redirect_i) begin
          flush   = 1'b1;
          load_pc = 1'b1;
        end else if (illegal) begin
          raise_fault = 1'b1;
          state_nxt   = S_FAULT;
        end else if ((count < CW'(QUEUE_DEPTH)) || pop) begin
          push = 1'b1;
        end
      end
      S_FAULT: begin
        if (redirect_i) begin
          flush       = 1'b1;
          load_pc     = 1'b1;
          clear_fault = 1'b1;
          state_nxt   = S_RUN;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc        <= BASE_ADDR;
      head            <= '0;
      tail            <= '0;
      count           <= '0;
      fault_o         <= 1'b0;
      fault_pc_o      <= '0;
      retired_count_o <= '0;
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        q_pc[i]  <= '0;
        q_ins[i] <= '0;
      end
    end else begin
      if (load_pc)   fetch_pc <= redirect_pc_i;
      else if (push) fetch_pc <= fetch_pc + DATA_WIDTH'(4);

      if (flush) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (push) begin
          q_pc[tail]  <= fetch_pc;
          q_ins[tail] <= mem_instruction_i;
          tail        <= tail + PW'(1);
        end
        if (pop) head <= head + PW'(1);
        case ({push, pop})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
      end

      if (pop) retired_count_o <= retired_count_o + 32'd1;

      if (raise_fault) begin
        fault_o    <= 1'b1;
        fault_pc_o <= fetch_pc;
      end else if (clear_fault) begin
        fault_o <= 1'b0;
      end
    end
  end

  assign mem_address_o = fetch_pc;
  assign ir_valid_o    = (count != '0);
  assign instruction_o = q_ins[head];
  assign pc_o          = q_pc[head];
  assign pc_plus4_o    = q_pc[head] + DATA_WIDTH'(4);

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Bench for imem_fetch_ctrl: queue-based reference model checked every cycle plus directed literal checks.
module tb_imem_fetch_ctrl;

  localparam logic [31:0] BASE  = 32'h0040_0000;
  localparam int          DEPTH = 256;
  localparam int          QD    = 2;
  localparam logic [31:0] LIMIT = BASE + 32'd1024;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] mem_address_o, mem_instruction_i, redirect_pc_i;
  logic        redirect_i, ir_ready_i, ir_valid_o, fault_o;
  logic [31:0] instruction_o, pc_o, pc_plus4_o, fault_pc_o, retired_count_o;

  always #5 clk = ~clk;

  imem_fetch_ctrl #(
    .DATA_WIDTH(32), .MEMORY_DEPTH(DEPTH), .BASE_ADDR(BASE), .QUEUE_DEPTH(QD)
  ) dut (
    .clk(clk), .reset(reset),
    .mem_address_o(mem_address_o), .mem_instruction_i(mem_instruction_i),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .ir_ready_i(ir_ready_i), .ir_valid_o(ir_valid_o),
    .instruction_o(instruction_o), .pc_o(pc_o), .pc_plus4_o(pc_plus4_o),
    .fault_o(fault_o), .fault_pc_o(fault_pc_o), .retired_count_o(retired_count_o)
  );

  logic [31:0] rom [DEPTH];
  logic [31:0] offs;

  // Asynchronous ROM; out-of-range reads return a poison word.
  always_comb begin
    offs              = mem_address_o - BASE;
    mem_instruction_i = 32'hDEAD_BEEF;
    if (mem_address_o >= BASE && mem_address_o < LIMIT)
      mem_instruction_i = rom[offs[9:2]];
  end

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] m_fpc, m_retired, m_fault_pc;
  bit          m_started, m_faulted;
  int          total = 0;
  int          bad = 0;

  function automatic logic [31:0] rom_word(logic [31:0] a);
    logic [31:0] o;
    o = a - BASE;
    return rom[o[9:2]];
  endfunction

  function automatic bit legal(logic [31:0] a);
    return (a[1:0] == 2'b00) && (a >= BASE) && (a < LIMIT);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_fpc      = BASE;
    m_retired  = 0;
    m_fault_pc = 0;
    m_started  = 0;
    m_faulted  = 0;
  endtask

  // One rising edge of the reference behaviour, using the inputs held across it.
  task automatic model_step();
    bit popping;
    popping = (mq.size() != 0) && ir_ready_i && !redirect_i;
    if (!m_started) begin
      m_started = 1;
    end else if (redirect_i) begin
      mq.delete();
      m_fpc     = redirect_pc_i;
      m_faulted = 0;
    end else begin
      if (popping) begin
        void'(mq.pop_front());
        m_retired = m_retired + 1;
      end
      if (!m_faulted) begin
        if (!legal(m_fpc)) begin
          m_faulted  = 1;
          m_fault_pc = m_fpc;
        end else if (mq.size() < QD) begin
          mq.push_back('{pc: m_fpc, ins: rom_word(m_fpc)});
          m_fpc = m_fpc + 4;
        end
      end
    end
  endtask

  task automatic compare_all();
    chk("ir_valid", 32'(ir_valid_o), 32'(mq.size() != 0));
    chk("mem_address", mem_address_o, m_fpc);
    chk("fault", 32'(fault_o), 32'(m_faulted));
    chk("fault_pc", fault_pc_o, m_fault_pc);
    chk("retired", retired_count_o, m_retired);
    if (mq.size() != 0) begin
      chk("pc", pc_o, mq[0].pc);
      chk("instruction", instruction_o, mq[0].ins);
      chk("pc_plus4", pc_plus4_o, mq[0].pc + 32'd4);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (!reset) model_step();
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) rom[i] = 32'h1000_0000 + 32'(i) * 32'h0000_0111;
    rom[0] = 32'h2008_0005;
    rom[1] = 32'h2009_0007;
    reset = 1'b1; redirect_i = 1'b0; redirect_pc_i = '0; ir_ready_i = 1'b0;
    model_reset();

    #12;
    chk("rst_valid", 32'(ir_valid_o), 32'd0);
    chk("rst_ins", instruction_o, 32'd0);
    chk("rst_pc", pc_o, 32'd0);
    chk("rst_pc4", pc_plus4_o, 32'd4);
    chk("rst_fault", 32'(fault_o), 32'd0);
    chk("rst_fault_pc", fault_pc_o, 32'd0);
    chk("rst_retired", retired_count_o, 32'd0);
    chk("rst_addr", mem_address_o, 32'h0040_0000);

    // Start-up with decode always ready
    @(negedge clk);
    reset = 1'b0; ir_ready_i = 1'b1;
    tick(); chk("s1_e1_valid", 32'(ir_valid_o), 32'd0);
    tick(); chk("s1_e2_valid", 32'(ir_valid_o), 32'd1);
            chk("s1_e2_pc", pc_o, 32'h0040_0000);
            chk("s1_e2_ins", instruction_o, 32'h2008_0005);
    tick(); chk("s1_e3_pc", pc_o, 32'h0040_0004);
            chk("s1_e3_ins", instruction_o, 32'h2009_0007);
            chk("s1_e3_retired", retired_count_o, 32'd1);

    // Back-pressure fills the queue, then drains without bubbles
    reset = 1'b1; model_reset();
    tick();
    reset = 1'b0; ir_ready_i = 1'b0;
    repeat (5) tick();
    chk("s2_full_addr", mem_address_o, 32'h0040_0008);
    chk("s2_full_pc", pc_o, 32'h0040_0000);
    chk("s2_full_valid", 32'(ir_valid_o), 32'd1);
    ir_ready_i = 1'b1;
    tick(); chk("s2_pop1_pc", pc_o, 32'h0040_0004); chk("s2_pop1_ret", retired_count_o, 32'd1);
    tick(); chk("s2_pop2_pc", pc_o, 32'h0040_0008); chk("s2_pop2_ret", retired_count_o, 32'd2);
    tick(); chk("s2_pop3_valid", 32'(ir_valid_o), 32'd1); chk("s2_pop3_ret", retired_count_o, 32'd3);

    // Redirect overrides a simultaneous pop
    redirect_i = 1'b1; redirect_pc_i = 32'h0040_0020;
    tick(); chk("s3_bubble_valid", 32'(ir_valid_o), 32'd0);
            chk("s3_bubble_ret", retired_count_o, 32'd3);
    redirect_i = 1'b0;
    tick(); chk("s3_tgt_valid", 32'(ir_valid_o), 32'd1);
            chk("s3_tgt_pc", pc_o, 32'h0040_0020);
            chk("s3_tgt_ins", instruction_o, rom[8]);

    // Misaligned target faults one edge after the redirect
    redirect_i = 1'b1; redirect_pc_i = 32'h0040_0402;
    tick(); chk("s4_redir_fault", 32'(fault_o), 32'd0);
    redirect_i = 1'b0;
    tick(); chk("s4_fault", 32'(fault_o), 32'd1);
            chk("s4_fault_pc", fault_pc_o, 32'h0040_0402);
            chk("s4_no_push", 32'(ir_valid_o), 32'd0);
    tick(); chk("s4_hold_addr", mem_address_o, 32'h0040_0402);
    redirect_i = 1'b1; redirect_pc_i = 32'h0040_0000;
    tick(); chk("s4_clear", 32'(fault_o), 32'd0);
            chk("s4_fault_pc_hold", fault_pc_o, 32'h0040_0402);
    redirect_i = 1'b0;
    tick(); chk("s4_resume_pc", pc_o, 32'h0040_0000);

    // Running off the end of the ROM
    ir_ready_i = 1'b0; redirect_i = 1'b1; redirect_pc_i = 32'h0040_03F8;
    tick();
    redirect_i = 1'b0;
    tick(); tick();
    tick(); chk("s5_fault", 32'(fault_o), 32'd1);
            chk("s5_fault_pc", fault_pc_o, 32'h0040_0400);
            chk("s5_head_pc", pc_o, 32'h0040_03F8);
    ir_ready_i = 1'b1;
    tick(); chk("s5_last_pc", pc_o, 32'h0040_03FC);
            chk("s5_last_ins", instruction_o, rom[255]);
    tick(); chk("s5_drained", 32'(ir_valid_o), 32'd0);

    // Asynchronous reset with a full queue
    ir_ready_i = 1'b0; redirect_i = 1'b1; redirect_pc_i = 32'h0040_0000;
    tick();
    redirect_i = 1'b0;
    tick(); tick();
    chk("s6_full_addr", mem_address_o, 32'h0040_0008);
    #3 reset = 1'b1;
    #1;
    chk("s6_async_valid", 32'(ir_valid_o), 32'd0);
    chk("s6_async_fault", 32'(fault_o), 32'd0);
    chk("s6_async_addr", mem_address_o, 32'h0040_0000);
    chk("s6_async_pc", pc_o, 32'd0);
    model_reset();
    tick();
    reset = 1'b0; ir_ready_i = 1'b1;
    tick(); chk("s6_e1_valid", 32'(ir_valid_o), 32'd0);
    tick(); chk("s6_e2_pc", pc_o, 32'h0040_0000);
            chk("s6_e2_ins", instruction_o, 32'h2008_0005);
    tick(); chk("s6_e3_pc", pc_o, 32'h0040_0004);
            chk("s6_e3_retired", retired_count_o, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
